// File: rtl/tmds_half_splitter_pkg.sv
// tmds_half_splitter_pkg: shared TMDS symbol constants, triple type and lane helpers
package tmds_half_splitter_pkg;
    localparam logic [9:0] TMDS_CTRL0 = 10'b1101010100;
    localparam logic [4:0] CLK_PAT_HI = 5'b11111;
    localparam logic [4:0] CLK_PAT_LO = 5'b00000;
    localparam logic [20:0] PRBS_SEEDS = {7'h2A, 7'h55, 7'h01};
    typedef logic [29:0] sym3_t;
    function automatic logic [9:0] sym3_lane(input sym3_t s, input int unsigned n);
        return s[n*10 +: 10];
    endfunction
    function automatic sym3_t sym3_fill(input logic [9:0] f);
        return {f, f, f};
    endfunction
    function automatic logic [14:0] sym3_half(input sym3_t s, input logic hi);
        logic [9:0] l0, l1, l2;
        l0 = sym3_lane(s, 0);
        l1 = sym3_lane(s, 1);
        l2 = sym3_lane(s, 2);
        return hi ? {l2[9:5], l1[9:5], l0[9:5]} : {l2[4:0], l1[4:0], l0[4:0]};
    endfunction
    function automatic logic [16:0] prbs7_x10(input logic [6:0] s);
        logic [6:0] st;
        logic [9:0] b;
        st = s;
        b = '0;
        for (int i = 0; i < 10; i++) begin
            b[i] = st[6] ^ st[5];
            st = {st[5:0], b[i]};
        end
        return {st, b};
    endfunction
endpackage

// File: rtl/tmds_half_splitter_sym_fifo.sv
// tmds_sym_fifo: small synchronous FIFO of TMDS symbol triples
module tmds_sym_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 30,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          pclkx2,
    input  logic          serdes_rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic [AW:0]   count_o,
    output logic          empty_o
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0] cnt_q;
    logic wr, rd;
    assign wr = push_i && (cnt_q != DEPTH_C);
    assign rd = pop_i && (cnt_q != '0);
    assign dout_o = mem_q[rp_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);
    // Storage needs no reset; occupancy decides what is valid
    always_ff @(posedge pclkx2)
        if (wr) mem_q[wp_q] <= din_i;
    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge pclkx2 or posedge serdes_rst)
        if (serdes_rst) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            if (wr) wp_q <= wp_q + 1'b1;
            if (rd) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
        end
endmodule

// File: rtl/tmds_half_splitter.sv
// tmds_half_splitter: TMDS triples split into 5-bit halves per pclkx2 cycle; TMDS_SPLIT_PRBS_EN adds a PRBS7 test mode
module tmds_half_splitter
    import tmds_half_splitter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [9:0] FILL_SYM = TMDS_CTRL0,
    parameter int CNT_W = 16
) (
    input  logic             pclkx2,
    input  logic             serdes_rst,
    input  logic             enable,
`ifdef TMDS_SPLIT_PRBS_EN
    input  logic             prbs_mode,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [29:0]      in_data,
    output logic [4:0]       out_lane0,
    output logic [4:0]       out_lane1,
    output logic [4:0]       out_lane2,
    output logic [4:0]       out_clk,
    output logic             out_phase,
    output logic             underflow,
    output logic [CNT_W-1:0] underflow_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    sym3_t hold_q, hold_d, fifo_dout, prbs_sym;
    logic [AW:0] fifo_cnt;
    logic fifo_empty, push, pop, reload, prbs, uf_d;
    logic phase_q, ophase_q, uf_q;
    logic [14:0] lanes_q;
    logic [4:0] clk_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign in_ready = !serdes_rst && !prbs && (fifo_cnt < DEPTH_C);
    assign push = in_valid && in_ready;

    tmds_sym_fifo #(.DEPTH(DEPTH), .W(30)) u_fifo (
        .pclkx2     (pclkx2),
        .serdes_rst (serdes_rst),
        .push_i     (push),
        .pop_i      (pop),
        .din_i      (in_data),
        .dout_o     (fifo_dout),
        .count_o    (fifo_cnt),
        .empty_o    (fifo_empty)
    );

`ifdef TMDS_SPLIT_PRBS_EN
    logic [2:0][6:0] prbs_q, prbs_d;
    assign prbs = prbs_mode;
    // Ten PRBS7 steps per lane form the candidate hold value in test mode
    always_comb begin
        prbs_d = prbs_q;
        prbs_sym = '0;
        for (int k = 0; k < 3; k++) {prbs_d[k], prbs_sym[k*10 +: 10]} = prbs7_x10(prbs_q[k]);
    end
    // Generators advance only when a test-mode reload consumes their bits
    always_ff @(posedge pclkx2 or posedge serdes_rst)
        if (serdes_rst) prbs_q <= PRBS_SEEDS;
        else if (reload && prbs) prbs_q <= prbs_d;
`else
    assign prbs = 1'b0;
    assign prbs_sym = '0;
`endif

    // Reload the hold register while its high half is on the wire
    always_comb begin
        reload = ophase_q;
        pop = reload && enable && !prbs && !fifo_empty;
        uf_d = reload && enable && !prbs && fifo_empty;
        hold_d = !reload ? hold_q : prbs ? prbs_sym : pop ? fifo_dout : sym3_fill(FILL_SYM);
        cnt_d = (uf_d && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    // Register the half selected by phase, taken from the post-reload hold value
    always_ff @(posedge pclkx2 or posedge serdes_rst)
        if (serdes_rst) begin
            phase_q <= 1'b0;
            ophase_q <= 1'b0;
            hold_q <= sym3_fill(FILL_SYM);
            lanes_q <= '0;
            clk_q <= CLK_PAT_LO;
            uf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            phase_q <= !phase_q;
            ophase_q <= phase_q;
            hold_q <= hold_d;
            lanes_q <= sym3_half(hold_d, phase_q);
            clk_q <= phase_q ? CLK_PAT_LO : CLK_PAT_HI;
            uf_q <= uf_d;
            cnt_q <= cnt_d;
        end

    assign out_lane0 = lanes_q[4:0];
    assign out_lane1 = lanes_q[9:5];
    assign out_lane2 = lanes_q[14:10];
    assign out_clk = clk_q;
    assign out_phase = ophase_q;
    assign underflow = uf_q;
    assign underflow_cnt = cnt_q;
endmodule
